pwm_peripheral: RTL

//   Consumes the five 8-bit control registers written over SPI and drives 16 output pins.

---
 rtl/pwm_peripheral.sv | 75 +++++++
 1 files changed

// File: rtl/pwm_peripheral.sv
// pwm_peripheral: 16-pin output driver with per-pin force-low / force-high / shared 256-step PWM.
// Optional macro PWM_SHADOW_EN: latch the duty value only at period boundaries.
`default_nettype none

module pwm_peripheral #(
  parameter int unsigned CLK_DIV = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  localparam logic [15:0] PRESCALE_LAST = 16'(CLK_DIV - 1);

  logic [15:0] prescaler;
  logic [7:0]  step;
  logic [7:0]  active_duty;
  logic        tick;
  logic        wrap;
  logic        pwm;
  logic [15:0] en_out;
  logic [15:0] en_pwm;

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};
  assign tick   = (prescaler == PRESCALE_LAST);
  assign wrap   = tick && (step == 8'hFF);

  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler    <= 16'h0000;
      step         <= 8'h00;
      period_start <= 1'b0;
    end else begin
      prescaler    <= tick ? 16'h0000 : prescaler + 16'h0001;
      if (tick) begin
        step <= step + 8'h01;
      end
      period_start <= wrap;
    end
  end

`ifdef PWM_SHADOW_EN
  // Duty is held constant across a whole period so every period is glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_duty <= 8'h00;
    end else if (wrap) begin
      active_duty <= pwm_duty_cycle;
    end
  end
`else
  assign active_duty = pwm_duty_cycle;
`endif

  // 0xFF is special-cased so full scale really is 100% rather than 255/256.
  assign pwm = (active_duty == 8'hFF) ? 1'b1 : (step < active_duty);

  always_ff @(posedge clk) begin
    if (rst) begin
      out <= 16'h0000;
    end else begin
      out <= en_out & (~en_pwm | {16{pwm}});
    end
  end

endmodule

`default_nettype wire
